// File: rtl/data_mem_responder.sv
// Memory-side responder for the MEM stage: accepts one load/store at a time, answers after
// WAIT_CYCLES busy cycles with a one-cycle mem_done pulse, and stalls the pipeline meanwhile.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_done,
  output logic        mem_stall,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic [3:0]           wait_cnt;
  logic [ADDR_BITS-1:0] idx_q;
  logic [31:0]          wdata_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 misalign_q;
  logic                 err_q;
  logic [31:0]          mem [DEPTH];

  logic req;
  logic finish;
  logic bad;
  logic commit;
  logic unused_addr_bits;

  // Upper address bits only alias onto the array, so they are deliberately dropped.
  assign unused_addr_bits = ^addr[31:ADDR_BITS+2];

  assign req    = mem_read | mem_write;
  assign finish = (state == BUSY) && (wait_cnt == 4'd0);
  assign bad    = misalign_q | (rd_q & wr_q);
  assign commit = finish && wr_q && !bad && !reset;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req) next_state = BUSY;
      BUSY:    if (wait_cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    addr_err  = 1'b0;
    unique case (state)
      IDLE:    mem_stall = req;
      BUSY:    mem_stall = 1'b1;
      DONE: begin
        mem_done = 1'b1;
        addr_err = err_q;
      end
      default: mem_stall = 1'b0;
    endcase
  end

  // Request is captured once in IDLE; BUSY works only from the captured copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      rdata      <= 32'd0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        idx_q      <= addr[ADDR_BITS+1:2];
        wdata_q    <= wdata;
        rd_q       <= mem_read;
        wr_q       <= mem_write;
        misalign_q <= |addr[1:0];
        wait_cnt   <= 4'(WAIT_CYCLES - 1);
      end
      if (state == BUSY && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (finish) begin
        err_q <= bad;
        if (bad)       rdata <= 32'd0;
        else if (rd_q) rdata <= mem[idx_q];
      end
    end
  end

  // The array has no reset; a store aborted by reset never reaches it.
  always_ff @(posedge clock) begin
    if (commit) mem[idx_q] <= wdata_q;
  end

endmodule
